// File: rtl/reg_ctrl_sequencer.sv
// Instruction sequencer for the 8x8 register bank: decodes register-transfer ops and hands OUT reads downstream.
// Optional build macro SEQ_R0_READONLY_EN makes R0 a read-only constant (writes to it flag illegal_op).
module reg_ctrl_sequencer #(
   parameter int DATA_W  = 8,
   parameter int SEL_W   = 3,
   parameter int INSTR_W = 3 + SEL_W + 2 + DATA_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr_data,
   output logic               rb_read_en,
   output logic               rb_write_en,
   output logic [SEL_W-1:0]   rb_rx_sel,
   output logic [SEL_W-1:0]   rb_ry_sel,
   output logic               rb_indirect_en,
   output logic [DATA_W-1:0]  rb_wdata,
   input  logic [DATA_W-1:0]  rb_bus_data,
   input  logic [DATA_W-1:0]  rb_rx_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic               busy,
   output logic               illegal_op
);

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LDI = 3'b001;
   localparam logic [2:0] OP_MOV = 3'b010;
   localparam logic [2:0] OP_LDR = 3'b011;
   localparam logic [2:0] OP_OUT = 3'b100;
   localparam logic [2:0] OP_INC = 3'b101;

   typedef enum logic [1:0] {IDLE, EXEC, OUT_HOLD} state_t;

   state_t              state;
   logic [2:0]          op_q;
   logic [SEL_W-1:0]    rx_q;
   logic [DATA_W-1:0]   imm_q;
   logic [SEL_W-1:0]    ry_q;
   logic                wr_op;
   logic                wr_block;
   logic                unused_rsvd;

   assign ry_q        = imm_q[SEL_W-1:0];
   assign unused_rsvd = ^instr_data[DATA_W+1:DATA_W];
   assign busy        = (state != IDLE);
   assign wr_op       = (op_q == OP_LDI) || (op_q == OP_MOV) || (op_q == OP_LDR) || (op_q == OP_INC);

`ifdef SEQ_R0_READONLY_EN
   assign wr_block = (rx_q == '0);
`else
   assign wr_block = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         instr_ready <= 1'b0;
         op_q        <= OP_NOP;
         rx_q        <= '0;
         imm_q       <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         illegal_op  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid && instr_ready) begin
                  op_q        <= instr_data[INSTR_W-1 -: 3];
                  rx_q        <= instr_data[INSTR_W-4 -: SEL_W];
                  imm_q       <= instr_data[DATA_W-1:0];
                  instr_ready <= 1'b0;
                  state       <= EXEC;
               end else begin
                  instr_ready <= 1'b1;
               end
            end
            EXEC: begin
               if ((op_q[2:1] == 2'b11) || (wr_op && wr_block))
                  illegal_op <= 1'b1;
               // The bank read is combinational, so the OUT value is captured on this same edge.
               if (op_q == OP_OUT) begin
                  out_data  <= rb_bus_data;
                  out_valid <= 1'b1;
                  state     <= OUT_HOLD;
               end else begin
                  instr_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            OUT_HOLD: begin
               if (out_valid && out_ready) begin
                  out_valid   <= 1'b0;
                  instr_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bank controls decode from the latched instruction and exist only during EXEC, so reset kills them at once.
   always_comb begin
      rb_read_en     = 1'b0;
      rb_write_en    = 1'b0;
      rb_rx_sel      = '0;
      rb_ry_sel      = '0;
      rb_indirect_en = 1'b0;
      rb_wdata       = '0;
      if (state == EXEC) begin
         case (op_q)
            OP_LDI: begin
               if (!wr_block) begin
                  rb_write_en = 1'b1;
                  rb_rx_sel   = rx_q;
                  rb_wdata    = imm_q;
               end
            end
            OP_MOV, OP_LDR: begin
               rb_read_en     = 1'b1;
               rb_ry_sel      = ry_q;
               rb_indirect_en = (op_q == OP_LDR);
               if (!wr_block) begin
                  rb_write_en = 1'b1;
                  rb_rx_sel   = rx_q;
                  rb_wdata    = rb_bus_data;
               end
            end
            OP_OUT: begin
               rb_read_en = 1'b1;
               rb_ry_sel  = ry_q;
            end
            OP_INC: begin
               if (!wr_block) begin
                  rb_write_en = 1'b1;
                  rb_rx_sel   = rx_q;
                  rb_wdata    = rb_rx_data + {{(DATA_W-1){1'b0}}, 1'b1};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_ctrl_sequencer.sv
// Directed bench for reg_ctrl_sequencer with a behavioural 8x8 register bank closing the loop.
module tb_reg_ctrl_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr_data;
   logic        rb_read_en, rb_write_en, rb_indirect_en;
   logic [2:0]  rb_rx_sel, rb_ry_sel;
   logic [7:0]  rb_wdata, rb_bus_data, rb_rx_data;
   logic        out_valid, out_ready;
   logic [7:0]  out_data;
   logic        busy, illegal_op;

   int checks   = 0;
   int failures = 0;

   logic [7:0] bank [8] = '{default: 8'h00};

   always #5 clk = ~clk;

   reg_ctrl_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
      .rb_read_en(rb_read_en), .rb_write_en(rb_write_en),
      .rb_rx_sel(rb_rx_sel), .rb_ry_sel(rb_ry_sel),
      .rb_indirect_en(rb_indirect_en), .rb_wdata(rb_wdata),
      .rb_bus_data(rb_bus_data), .rb_rx_data(rb_rx_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .illegal_op(illegal_op)
   );

   // Register bank model: combinational reads, write on the rising edge.
   assign rb_bus_data = !rb_read_en ? 8'h00 :
                        rb_indirect_en ? bank[bank[rb_ry_sel][2:0]] : bank[rb_ry_sel];
   assign rb_rx_data  = bank[rb_rx_sel];
   always @(posedge clk) if (rb_write_en) bank[rb_rx_sel] <= rb_wdata;

   typedef struct {
      logic [2:0] op;
      logic [2:0] rx;
      logic [7:0] lo;
      logic       we, re, ind;
      logic [2:0] xs, ys;
      logic [7:0] wd;
      logic       is_out;
      logic [7:0] od;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the EXEC cycle.
   task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rx, input logic [7:0] lo);
      int n = 0;
      while (!instr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) check("instr_ready_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b1;
      instr_data  = {op, rx, 2'b10, lo};
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      instr_data  = 16'hFFFF;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      string t;
      t = $sformatf("v%0d", idx);
      check({t, "_write_en"}, 32'(rb_write_en), 32'(v.we));
      check({t, "_read_en"}, 32'(rb_read_en), 32'(v.re));
      check({t, "_indirect"}, 32'(rb_indirect_en), 32'(v.ind));
      check({t, "_rx_sel"}, 32'(rb_rx_sel), 32'(v.xs));
      check({t, "_ry_sel"}, 32'(rb_ry_sel), 32'(v.ys));
      if (v.we) check({t, "_wdata"}, 32'(rb_wdata), 32'(v.wd));
      @(negedge clk);
      if (v.is_out) begin
         check({t, "_out_valid"}, 32'(out_valid), 32'd1);
         check({t, "_out_data"}, 32'(out_data), 32'(v.od));
         @(negedge clk);
      end
      check({t, "_idle"}, 32'({busy, instr_ready}), 32'b01);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      //                op    rx    lo     we    re    ind   xs    ys    wd     out   od
      vecs[0]  = '{3'd1, 3'd3, 8'h5A, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0, 8'h5A, 1'b0, 8'h00};
      vecs[1]  = '{3'd4, 3'd6, 8'h03, 1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 8'h00, 1'b1, 8'h5A};
      vecs[2]  = '{3'd1, 3'd1, 8'h07, 1'b1, 1'b0, 1'b0, 3'd1, 3'd0, 8'h07, 1'b0, 8'h00};
      vecs[3]  = '{3'd1, 3'd7, 8'hC3, 1'b1, 1'b0, 1'b0, 3'd7, 3'd0, 8'hC3, 1'b0, 8'h00};
      vecs[4]  = '{3'd3, 3'd2, 8'h01, 1'b1, 1'b1, 1'b1, 3'd2, 3'd1, 8'hC3, 1'b0, 8'h00};
      vecs[5]  = '{3'd4, 3'd0, 8'h02, 1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 8'h00, 1'b1, 8'hC3};
      vecs[6]  = '{3'd1, 3'd4, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd4, 3'd0, 8'hFF, 1'b0, 8'h00};
      vecs[7]  = '{3'd5, 3'd4, 8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 3'd0, 8'h00, 1'b0, 8'h00};
      vecs[8]  = '{3'd4, 3'd0, 8'h04, 1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 8'h00, 1'b1, 8'h00};
      vecs[9]  = '{3'd5, 3'd4, 8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 3'd0, 8'h01, 1'b0, 8'h00};
      vecs[10] = '{3'd4, 3'd0, 8'h04, 1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 8'h00, 1'b1, 8'h01};
      vecs[11] = '{3'd2, 3'd5, 8'h03, 1'b1, 1'b1, 1'b0, 3'd5, 3'd3, 8'h5A, 1'b0, 8'h00};
      vecs[12] = '{3'd2, 3'd3, 8'h03, 1'b1, 1'b1, 1'b0, 3'd3, 3'd3, 8'h5A, 1'b0, 8'h00};
      vecs[13] = '{3'd0, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b0, 8'h00};

      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr_data  = 16'h0000;
      out_ready   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_instr_ready", 32'(instr_ready), 32'd0);
      check("rst_enables", 32'({rb_read_en, rb_write_en, rb_indirect_en}), 32'd0);
      check("rst_sels_wdata", 32'({rb_rx_sel, rb_ry_sel, rb_wdata}), 32'd0);
      check("rst_out", 32'({out_valid, out_data}), 32'd0);
      check("rst_busy_illegal", 32'({busy, illegal_op}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_instr_ready", 32'(instr_ready), 32'd1);

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].op, vecs[i].rx, vecs[i].lo);
         checkOutput(vecs[i], i);
      end
      check("illegal_after_legal", 32'(illegal_op), 32'd0);

      // OUT R5 with downstream stalled for 10 cycles.
      out_ready = 1'b0;
      applyStimulus(3'd4, 3'd0, 8'h05);
      check("stall_exec_read", 32'(rb_read_en), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("stall%0d_hold", i),
               32'({out_valid, instr_ready, busy, rb_read_en, out_data}), 32'({4'b1010, 8'h5A}));
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_release", 32'({out_valid, busy, instr_ready}), 32'b001);

      // Illegal opcode is sticky over further legal ops.
      applyStimulus(3'd6, 3'd2, 8'h33);
      check("illegal_no_enables", 32'({rb_read_en, rb_write_en, rb_indirect_en}), 32'd0);
      @(negedge clk);
      check("illegal_set", 32'(illegal_op), 32'd1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(3'd0, 3'd0, 8'h00);
         @(negedge clk);
      end
      check("illegal_sticky", 32'(illegal_op), 32'd1);

      // Reset during EXEC of LDI R6,0xAA.
      applyStimulus(3'd1, 3'd6, 8'hAA);
      check("rst_exec_we_before", 32'(rb_write_en), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_exec_enables", 32'({rb_write_en, rb_rx_sel, rb_wdata}), 32'd0);
      check("rst_exec_state", 32'({busy, illegal_op, out_valid, instr_ready}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(3'd4, 3'd0, 8'h06);
      @(negedge clk);
      check("r6_unchanged", 32'({out_valid, out_data}), 32'({1'b1, 8'h00}));
      @(negedge clk);

      // Write to R0.
      applyStimulus(3'd1, 3'd0, 8'h11);
`ifdef SEQ_R0_READONLY_EN
      check("r0_write_en", 32'(rb_write_en), 32'd0);
`else
      check("r0_write_en", 32'(rb_write_en), 32'd1);
`endif
      @(negedge clk);
      applyStimulus(3'd4, 3'd0, 8'h00);
      @(negedge clk);
`ifdef SEQ_R0_READONLY_EN
      check("r0_out", 32'({out_valid, out_data, illegal_op}), 32'({1'b1, 8'h00, 1'b1}));
`else
      check("r0_out", 32'({out_valid, out_data, illegal_op}), 32'({1'b1, 8'h11, 1'b0}));
`endif
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
